// File: rtl/vga_axil_pkg.sv
// Package shared by the VGA AXI-Lite register file and its sub-modules.
// Holds the native bus types, register byte offsets, the CTRL and STATUS
// field layouts, the shadow-transfer FSM state type and an address-match
// helper that ignores the byte-lane bits [1:0].
package vga_axil_pkg;

  localparam int NATIVE_ADDR_W = 8;
  localparam int AXIL_DATA_W   = 32;

  typedef logic [NATIVE_ADDR_W-1:0] native_addr_t;
  typedef logic [AXIL_DATA_W-1:0]   axil_data_t;

  localparam native_addr_t REG_CTRL     = 8'h00;
  localparam native_addr_t REG_H_ACTIVE = 8'h04;
  localparam native_addr_t REG_V_ACTIVE = 8'h08;
  localparam native_addr_t REG_FB_BASE  = 8'h0C;
  localparam native_addr_t REG_STATUS   = 8'h10;
  localparam native_addr_t REG_SCRATCH  = 8'h14;

  // CTRL register, bit 0 is the LSB (enable).
  typedef struct packed {
    logic test_pattern;
    logic underflow_irq_en;
    logic frame_irq_en;
    logic enable;
  } ctrl_t;

  // W1C status bits, bit 0 is frame_irq.
  typedef struct packed {
    logic underflow;
    logic frame_irq;
  } status_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } xfer_state_e;

  // Word-granular address match.
  function automatic logic addr_hit(input logic [NATIVE_ADDR_W-3:0] word_idx,
                                    input native_addr_t off);
    return word_idx == off[NATIVE_ADDR_W-1:2];
  endfunction

endpackage

// File: rtl/vga_shadow_reg.sv
// Shadow/active register pair.
// Ports:
//   clk_i, arst_ni : clock, asynchronous active-low reset
//   we_i, d_i      : shadow write strobe and data
//   imm_i          : immediate mode, a shadow write also loads the active copy
//   xfer_i         : frame-boundary transfer, active copy takes the shadow
//                    value as it was before any same-edge write
//   shadow_o       : shadow copy (software readback)
//   active_o       : active copy (drives the hardware)
module vga_shadow_reg #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         arst_ni,
  input  logic         we_i,
  input  logic [W-1:0] d_i,
  input  logic         imm_i,
  input  logic         xfer_i,
  output logic [W-1:0] shadow_o,
  output logic [W-1:0] active_o
);

  logic [W-1:0] shadow_q;
  logic [W-1:0] active_q;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      if (we_i) shadow_q <= d_i;
      // Transfer uses shadow_q, so a coinciding write waits one frame.
      if (xfer_i)            active_q <= shadow_q;
      else if (imm_i && we_i) active_q <= d_i;
    end
  end

  assign shadow_o = shadow_q;
  assign active_o = active_q;

endmodule

// File: rtl/vga_axil_regfile.sv
// VGA configuration register file on the native side of the AXI-Lite slave.
// Ports:
//   clk_i, arst_ni                  : clock, asynchronous active-low reset
//   write_en_i, addr_write_i, data_i: native write strobe/address/data
//   read_en_sync_i, addr_read_i     : native read strobe/address
//   data_o                          : registered read data (held until next read)
//   frame_start_i, underflow_i      : event pulses from the video pipeline
//   enable_o, test_pattern_o        : active CTRL fields
//   h_active_o, v_active_o, fb_base_o : active timing / framebuffer config
//   irq_o                           : registered level interrupt
module vga_axil_regfile
  import vga_axil_pkg::*;
#(
  parameter int H_WIDTH    = 12,
  parameter int V_WIDTH    = 12,
  parameter int FCNT_WIDTH = 16
) (
  input  logic               clk_i,
  input  logic               arst_ni,
  input  logic               write_en_i,
  input  native_addr_t       addr_write_i,
  input  axil_data_t         data_i,
  input  logic               read_en_sync_i,
  input  native_addr_t       addr_read_i,
  output axil_data_t         data_o,
  input  logic               frame_start_i,
  input  logic               underflow_i,
  output logic               enable_o,
  output logic               test_pattern_o,
  output logic [H_WIDTH-1:0] h_active_o,
  output logic [V_WIDTH-1:0] v_active_o,
  output logic [31:0]        fb_base_o,
  output logic               irq_o
);

  localparam int WI = NATIVE_ADDR_W - 2;

  logic [WI-1:0] wr_idx, rd_idx;
  logic          unused_addr_lsbs;
  assign wr_idx           = addr_write_i[NATIVE_ADDR_W-1:2];
  assign rd_idx           = addr_read_i[NATIVE_ADDR_W-1:2];
  assign unused_addr_lsbs = ^{addr_write_i[1:0], addr_read_i[1:0]};

  logic wr_ctrl, wr_h, wr_v, wr_fb, wr_status, wr_scratch;
  assign wr_ctrl    = write_en_i && addr_hit(wr_idx, REG_CTRL);
  assign wr_h       = write_en_i && addr_hit(wr_idx, REG_H_ACTIVE);
  assign wr_v       = write_en_i && addr_hit(wr_idx, REG_V_ACTIVE);
  assign wr_fb      = write_en_i && addr_hit(wr_idx, REG_FB_BASE);
  assign wr_status  = write_en_i && addr_hit(wr_idx, REG_STATUS);
  assign wr_scratch = write_en_i && addr_hit(wr_idx, REG_SCRATCH);

  // ---------------- shadow transfer FSM ----------------
  xfer_state_e state_q, state_d;
  logic        imm_load, xfer;
  ctrl_t       ctrl_sh, ctrl_act;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (wr_ctrl && data_i[0])               state_d = ST_RUN;
      ST_RUN:  if (frame_start_i && !ctrl_sh.enable)    state_d = ST_IDLE;
      default:                                          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    imm_load = (state_q == ST_IDLE);
    xfer     = (state_q == ST_RUN) && frame_start_i;
  end

  // ---------------- shadow/active pairs ----------------
  logic [H_WIDTH-1:0] h_sh;
  logic [V_WIDTH-1:0] v_sh;
  logic [31:0]        fb_sh;

  vga_shadow_reg #(.W(4)) u_ctrl (
    .clk_i(clk_i), .arst_ni(arst_ni), .we_i(wr_ctrl), .d_i(data_i[3:0]),
    .imm_i(imm_load), .xfer_i(xfer), .shadow_o(ctrl_sh), .active_o(ctrl_act)
  );
  vga_shadow_reg #(.W(H_WIDTH)) u_h (
    .clk_i(clk_i), .arst_ni(arst_ni), .we_i(wr_h), .d_i(data_i[H_WIDTH-1:0]),
    .imm_i(imm_load), .xfer_i(xfer), .shadow_o(h_sh), .active_o(h_active_o)
  );
  vga_shadow_reg #(.W(V_WIDTH)) u_v (
    .clk_i(clk_i), .arst_ni(arst_ni), .we_i(wr_v), .d_i(data_i[V_WIDTH-1:0]),
    .imm_i(imm_load), .xfer_i(xfer), .shadow_o(v_sh), .active_o(v_active_o)
  );
  vga_shadow_reg #(.W(32)) u_fb (
    .clk_i(clk_i), .arst_ni(arst_ni), .we_i(wr_fb), .d_i(data_i),
    .imm_i(imm_load), .xfer_i(xfer), .shadow_o(fb_sh), .active_o(fb_base_o)
  );

  assign enable_o       = ctrl_act.enable;
  assign test_pattern_o = ctrl_act.test_pattern;

  // ---------------- status, counter, scratch, irq ----------------
  status_t               status_q, status_d;
  logic [FCNT_WIDTH-1:0] fcnt_q;
  axil_data_t            scratch_q;
  logic                  irq_q;

  // Hardware set dominates a same-cycle W1C.
  always_comb begin
    status_d           = status_q;
    status_d.frame_irq = frame_start_i ||
                         (status_q.frame_irq && !(wr_status && data_i[0]));
    status_d.underflow = underflow_i ||
                         (status_q.underflow && !(wr_status && data_i[1]));
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      status_q  <= '0;
      fcnt_q    <= '0;
      scratch_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      status_q <= status_d;
      if (state_q == ST_RUN && frame_start_i) fcnt_q <= fcnt_q + 1'b1;
      if (wr_scratch) scratch_q <= data_i;
      irq_q <= (status_q.frame_irq && ctrl_act.frame_irq_en) ||
               (status_q.underflow && ctrl_act.underflow_irq_en);
    end
  end

  assign irq_o = irq_q;

  // ---------------- read path ----------------
  axil_data_t  rd_data, data_q;
  logic [15:0] fcnt_rd;
  assign fcnt_rd = 16'(fcnt_q);

  always_comb begin
    rd_data = '0;
    if (addr_hit(rd_idx, REG_CTRL))          rd_data[3:0]         = ctrl_sh;
    else if (addr_hit(rd_idx, REG_H_ACTIVE)) rd_data[H_WIDTH-1:0] = h_sh;
    else if (addr_hit(rd_idx, REG_V_ACTIVE)) rd_data[V_WIDTH-1:0] = v_sh;
    else if (addr_hit(rd_idx, REG_FB_BASE))  rd_data              = fb_sh;
    else if (addr_hit(rd_idx, REG_STATUS))   rd_data = {fcnt_rd, 14'd0, status_q};
    else if (addr_hit(rd_idx, REG_SCRATCH))  rd_data              = scratch_q;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni)            data_q <= '0;
    else if (read_en_sync_i) data_q <= rd_data;
  end

  assign data_o = data_q;

endmodule

// File: tb/tb_vga_axil_regfile.sv
module tb_vga_axil_regfile;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        write_en = 1'b0;
  logic [7:0]  addr_write = '0;
  logic [31:0] data_in = '0;
  logic        read_en = 1'b0;
  logic [7:0]  addr_read = '0;
  logic [31:0] data_out;
  logic        frame_start = 1'b0;
  logic        underflow = 1'b0;
  logic        enable;
  logic        test_pattern;
  logic [11:0] h_active;
  logic [11:0] v_active;
  logic [31:0] fb_base;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_axil_regfile dut (
    .clk_i(clk), .arst_ni(arst_n),
    .write_en_i(write_en), .addr_write_i(addr_write), .data_i(data_in),
    .read_en_sync_i(read_en), .addr_read_i(addr_read), .data_o(data_out),
    .frame_start_i(frame_start), .underflow_i(underflow),
    .enable_o(enable), .test_pattern_o(test_pattern),
    .h_active_o(h_active), .v_active_o(v_active), .fb_base_o(fb_base),
    .irq_o(irq)
  );

  typedef struct {
    logic [31:0] exp;
    string       name;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", nm, act);
    end
  endtask

  // One clock cycle of stimulus; read expectations go through the scoreboard.
  task automatic cyc(input logic we, input logic [7:0] wa, input logic [31:0] wd,
                     input logic re, input logic [7:0] ra, input logic [31:0] exp,
                     input logic fs, input logic uf, input string nm);
    sb_t e;
    write_en = we; addr_write = wa; data_in = wd;
    read_en = re; addr_read = ra;
    frame_start = fs; underflow = uf;
    if (re) sb_q.push_back('{exp, nm});
    @(posedge clk); #1;
    write_en = 1'b0; read_en = 1'b0; frame_start = 1'b0; underflow = 1'b0;
    if (re) begin
      if (sb_q.size() == 0) begin
        check({nm, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check(e.name, data_out, e.exp);
      end
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    cyc(1'b1, a, d, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, "");
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string nm);
    cyc(1'b0, 8'h00, 32'h0, 1'b1, a, exp, 1'b0, 1'b0, nm);
  endtask

  task automatic frame();
    cyc(1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, "");
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0, "");
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    #1;
    @(posedge clk); #1;
    arst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0] = '{8'h04, 32'h0000_0280, 32'h0000_0280};
    vecs[1] = '{8'h05, 32'h0000_0123, 32'h0000_0123};
    vecs[2] = '{8'h08, 32'h0FFF_F1E0, 32'h0000_01E0};
    vecs[3] = '{8'h0C, 32'h8000_0004, 32'h8000_0004};
    vecs[4] = '{8'h14, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[5] = '{8'h00, 32'hFFFF_FFF8, 32'h0000_0008};
    vecs[6] = '{8'h40, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[7] = '{8'h10, 32'hFFFF_FFFF, 32'h0000_0000};

    // Reset state
    #12;
    check("rst_enable", {31'd0, enable}, 32'h0);
    check("rst_test_pattern", {31'd0, test_pattern}, 32'h0);
    check("rst_h_v", {8'd0, h_active, v_active}, 32'h0);
    check("rst_fb_base", fb_base, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    check("rst_data_o", data_out, 32'h0);
    @(posedge clk); #1;
    arst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) rd(8'(i * 4), 32'h0, $sformatf("rst_read_%02h", i * 4));

    // IDLE writes take effect immediately
    wr(8'h04, 32'h280);
    check("idle_h_active_immediate", {20'd0, h_active}, 32'h280);
    for (int i = 0; i < 8; i++) begin
      wr(vecs[i].addr, vecs[i].wdata);
      rd(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d_read_%02h", i, vecs[i].addr));
    end
    check("idle_h_active", {20'd0, h_active}, 32'h123);
    check("idle_v_active", {20'd0, v_active}, 32'h1E0);
    check("idle_fb_base", fb_base, 32'h8000_0004);
    check("idle_test_pattern", {31'd0, test_pattern}, 32'h1);
    check("idle_enable_off", {31'd0, enable}, 32'h0);

    // Same-cycle read and write of one address returns the old value
    cyc(1'b1, 8'h14, 32'h1111_2222, 1'b1, 8'h14, 32'hDEAD_BEEF, 1'b0, 1'b0, "rw_same_cycle_old");
    rd(8'h14, 32'h1111_2222, "rw_same_cycle_new");
    wr(8'h00, 32'h0);
    check("idle_test_pattern_clear", {31'd0, test_pattern}, 32'h0);

    // RUN: deferred transfer
    wr(8'h00, 32'h1);
    check("run_enable_immediate", {31'd0, enable}, 32'h1);
    wr(8'h0C, 32'h1000_0000);
    idle();
    check("run_fb_deferred", fb_base, 32'h8000_0004);
    rd(8'h0C, 32'h1000_0000, "run_fb_shadow_read");
    frame();
    check("run_fb_at_frame", fb_base, 32'h1000_0000);
    cyc(1'b1, 8'h0C, 32'h2000_0000, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, "");
    check("run_fb_write_at_frame_deferred", fb_base, 32'h1000_0000);
    rd(8'h0C, 32'h2000_0000, "run_fb_shadow_read2");
    frame();
    check("run_fb_next_frame", fb_base, 32'h2000_0000);
    rd(8'h10, 32'h0003_0001, "run_status_3_frames");

    // Asynchronous reset mid-RUN
    #2;
    arst_n = 1'b0;
    #1;
    check("arst_enable", {31'd0, enable}, 32'h0);
    check("arst_fb_base", fb_base, 32'h0);
    check("arst_data_o", data_out, 32'h0);
    @(posedge clk); #1;
    arst_n = 1'b1;
    @(posedge clk); #1;
    rd(8'h10, 32'h0, "arst_status_zero");
    frame();
    rd(8'h0C, 32'h0, "arst_no_pending_fb");
    check("arst_fb_stays_zero", fb_base, 32'h0);

    // Interrupt sequence (count restarts from 0 after the reset above)
    rd(8'h10, 32'h0000_0001, "idle_frame_sets_bit0_no_count");
    wr(8'h10, 32'h1);
    wr(8'h00, 32'h3);
    frame(); frame(); frame();
    rd(8'h10, 32'h0003_0001, "irq_status_3_frames");
    check("irq_asserted", {31'd0, irq}, 32'h1);
    wr(8'h10, 32'h1);
    check("irq_latency_after_w1c", {31'd0, irq}, 32'h1);
    idle();
    check("irq_cleared", {31'd0, irq}, 32'h0);
    rd(8'h10, 32'h0003_0000, "status_after_w1c");
    cyc(1'b1, 8'h10, 32'h1, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, "");
    rd(8'h10, 32'h0004_0001, "w1c_vs_set_set_wins");
    cyc(1'b0, 8'h00, 32'h0, 1'b0, 8'h00, 32'h0, 1'b0, 1'b1, "");
    rd(8'h10, 32'h0004_0003, "underflow_set");
    cyc(1'b1, 8'h10, 32'h2, 1'b0, 8'h00, 32'h0, 1'b0, 1'b1, "");
    rd(8'h10, 32'h0004_0003, "underflow_w1c_vs_set");

    // RUN -> IDLE only at a frame boundary
    wr(8'h00, 32'h0);
    check("run_enable_held", {31'd0, enable}, 32'h1);
    frame();
    check("run_to_idle_at_frame", {31'd0, enable}, 32'h0);
    frame();
    rd(8'h10, 32'h0005_0003, "idle_frames_not_counted");

    // Frame counter wrap
    do_reset();
    wr(8'h00, 32'h1);
    for (int i = 0; i < 65535; i++) frame();
    rd(8'h10, 32'hFFFF_0001, "fcnt_max");
    frame();
    rd(8'h10, 32'h0000_0001, "fcnt_wrap");

    if (sb_q.size() != 0) check("sb_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_axil_regfile.md
Name: vga_axil_regfile

Overview:
- Native-side register file directly downstream of vga_axil_slave_fsm.
- Consumes its native write strobe/address/data and read strobe/address; returns read data one cycle later.
- Holds VGA timing/framebuffer configuration in shadow registers and transfers them to active registers at frame boundaries; keeps W1C interrupt status and a frame counter.
- Drives the config and interrupt for the VGA timing generator and DMA.

Parameters:
- H_WIDTH, 12, width of horizontal active-pixel field
- V_WIDTH, 12, width of vertical active-line field
- FCNT_WIDTH, 16, frame counter width

Ports:
- clk_i  in  1  system clock
- arst_ni  in  1  asynchronous active-low reset
- write_en_i  in  1  native write strobe from slave FSM
- addr_write_i  in  native_addr_t  native write byte address
- data_i  in  axil_data_t (32)  native write data
- read_en_sync_i  in  1  native read strobe from slave FSM
- addr_read_i  in  native_addr_t  native read byte address
- data_o  out  axil_data_t (32)  read data to slave FSM
- frame_start_i  in  1  one-cycle pulse, first pixel of frame
- underflow_i  in  1  one-cycle pulse, pixel FIFO underflow
- enable_o  out  1  active CTRL.enable
- test_pattern_o  out  1  active CTRL.test_pattern
- h_active_o  out  H_WIDTH  active horizontal size
- v_active_o  out  V_WIDTH  active vertical size
- fb_base_o  out  32  active framebuffer base
- irq_o  out  1  level interrupt

Behaviour:
- Address decode: bits [1:0] ignored. Map:
  - 0x00 CTRL (shadow): [0] enable, [1] frame_irq_en, [2] underflow_irq_en, [3] test_pattern
  - 0x04 H_ACTIVE (shadow)
  - 0x08 V_ACTIVE (shadow)
  - 0x0C FB_BASE (shadow)
  - 0x10 STATUS: [0] frame_irq W1C, [1] underflow W1C, [31:16] frame count RO
  - 0x14 SCRATCH (RW)
- Unmapped writes ignored; unmapped reads return 0. Unused bits read 0, writes to them ignored.
- Reset values: all shadow, active, status and scratch registers 0; data_o 0; irq_o 0. Every output is a register or a pure function of registers.
- Write: on a clk_i edge with write_en_i=1, the addressed register is updated; visible on the next cycle.
- Read: read_en_sync_i=1 at edge N → data_o holds the value of addr_read_i at edge N+1. data_o holds that value until the next read.
  - Shadow addresses read the shadow copy.
  - A read and a write to the same address in the same cycle return the pre-write value.
- Shadow→active transfer (two-state FSM):
  - IDLE: active_enable=0. Each shadow write copies to its active register on the same edge as the shadow write.
  - RUN: active_enable=1. All shadows copy to actives atomically on an edge with frame_start_i=1.
  - IDLE→RUN when a CTRL write sets enable (applied immediately).
  - RUN→IDLE only at frame_start_i when shadow enable=0.
  - A shadow write coinciding with frame_start_i: actives take the pre-write shadow; the new value applies at the next frame.
- STATUS:
  - frame_start_i sets [0]; underflow_i sets [1].
  - Writing 1 clears a bit; when a hardware set and a W1C of the same bit fall in the same cycle, set wins.
  - Frame count increments on every frame_start_i in RUN and wraps 0xFFFF→0x0000. Cleared only by reset.
- irq_o registered: (status[0] & ctrl.frame_irq_en) | (status[1] & ctrl.underflow_irq_en), using active CTRL, one-cycle latency.
- Reset mid-operation: all state returns to reset values immediately (async). No pending transfer survives.

Decomposition:
- vga_axil_pkg: native_addr_t and axil_data_t (already present); add the register offset constants (REG_CTRL..REG_SCRATCH), a ctrl_t packed struct, and a status_t packed struct.
- One natural sub-module: vga_shadow_reg (parameterised width; shadow + active pair with immediate/deferred load).

Test Plan:
- Reset → all outputs 0; read of each of 0x00–0x14 returns 0x0.
- IDLE write 0x04←0x280 → h_active_o=0x280 the next cycle; read of 0x04 returns 0x280 one cycle after read_en_sync_i.
- Write 0x00←0x1 (enable), then 0x0C←0x1000_0000 → fb_base_o stays at its old value until frame_start_i, then becomes 0x1000_0000. A write coinciding with frame_start_i is deferred one frame.
- Sequence:
  - Set frame_irq_en=1; 3 frame_start_i pulses → STATUS reads 0x0003_0001 and irq_o=1.
  - Write 0x10←0x1 → irq_o=0.
  - W1C coinciding with frame_start_i → bit[0] remains 1.
- Preload frame counter to 0xFFFF by 65535 pulses, then one more pulse → count reads 0x0000.
- Unmapped 0x40←0xDEAD_BEEF then read 0x40 → 0x0. Assert arst_ni mid-RUN → enable_o=0 and the STATUS count is 0 immediately.
